// File: rtl/conv_sched.sv
// ---------------------------------------------------------------------------
// conv_sched
//
// Purpose:
//   Sequencer for the first convolution layer. One multiply-accumulate unit
//   is shared across every output pixel and every filter. For each window
//   (out_x, out_y, filt) this block issues one image-buffer read and one
//   weight-buffer read per cycle, covering all kernel taps. It drives the MAC
//   strobes one cycle later, when the read data arrives, and then offers the
//   finished sum to the result buffer.
//
//   Loop order, outer to inner: out_x, out_y, filt, i, j.
//   Cost per output with res_ready held high:
//     WEIGHT_X*WEIGHT_Y read cycles + 1 drain cycle + 1 write cycle.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   start        one-cycle request to run the whole layer (ignored unless idle)
//   busy         high while a layer run is in progress (low in the done cycle)
//   done         one-cycle pulse after the final result handshake
//   data_rd_en   image buffer read strobe
//   data_rd_x    image row    = out_x + i
//   data_rd_y    image column = out_y + j
//   wt_rd_en     weight buffer read strobe (same as data_rd_en)
//   wt_rd_filt   filter index
//   wt_rd_i      kernel row
//   wt_rd_j      kernel column
//   mac_acc      read data valid this cycle; MAC consumes the product
//   mac_first    with mac_acc: MAC loads the product instead of adding it
//   mac_last     with mac_acc: final tap of the window
//   res_valid    MAC output holds a complete sum
//   res_ready    result buffer accepts the sum
//   res_filt     filter index of the presented result
//   res_x        output row of the presented result
//   res_y        output column of the presented result
//   dbg_state    current FSM state, for observation only
//
// Result handshake:
//   A result transfers on a cycle where res_valid and res_ready are both
//   high. Once res_valid rises it stays high, with res_filt/res_x/res_y
//   unchanged, until that transfer. res_ready may toggle freely, and nothing
//   else in the block moves while the result waits.
// ---------------------------------------------------------------------------
module conv_sched #(
    parameter int DATA_X   = 28,
    parameter int DATA_Y   = 28,
    parameter int WEIGHT_X = 5,
    parameter int WEIGHT_Y = 5,
    parameter int NUM_FILT = 8,
    localparam int CONV_X  = DATA_X - WEIGHT_X + 1,
    localparam int CONV_Y  = DATA_Y - WEIGHT_Y + 1,
    localparam int TAPS    = WEIGHT_X * WEIGHT_Y,
    localparam int AW      = $clog2((DATA_X > DATA_Y) ? DATA_X : DATA_Y),
    localparam int KW      = 3,
    localparam int FW      = (NUM_FILT > 1) ? $clog2(NUM_FILT) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          data_rd_en,
    output logic [AW-1:0] data_rd_x,
    output logic [AW-1:0] data_rd_y,
    output logic          wt_rd_en,
    output logic [FW-1:0] wt_rd_filt,
    output logic [KW-1:0] wt_rd_i,
    output logic [KW-1:0] wt_rd_j,
    output logic          mac_acc,
    output logic          mac_first,
    output logic          mac_last,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [FW-1:0] res_filt,
    output logic [AW-1:0] res_x,
    output logic [AW-1:0] res_y,
    output logic [2:0]    dbg_state
);

    // FSM encoding
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_FIN   = 3'd4;

    // Counter bounds, sized to the counters they are compared against
    localparam logic [KW-1:0] KI_MAX = KW'(WEIGHT_X - 1);
    localparam logic [KW-1:0] KJ_MAX = KW'(WEIGHT_Y - 1);
    localparam logic [FW-1:0] F_MAX  = FW'(NUM_FILT - 1);
    localparam logic [AW-1:0] OX_MAX = AW'(CONV_X - 1);
    localparam logic [AW-1:0] OY_MAX = AW'(CONV_Y - 1);

    // State and loop counters
    logic [2:0]    r_state;
    logic [AW-1:0] r_out_x;
    logic [AW-1:0] r_out_y;
    logic [FW-1:0] r_filt;
    logic [KW-1:0] r_ki;
    logic [KW-1:0] r_kj;

    // MAC strobe pipeline: read strobe and tap flags delayed by one register
    // stage to line up with the one-cycle buffer read latency
    logic r_mac_acc;
    logic r_mac_first;
    logic r_mac_last;

    logic w_rd_en;
    logic w_first_tap;
    logic w_last_tap;
    logic w_filt_wrap;
    logic w_y_wrap;
    logic w_x_wrap;
    logic w_last_window;
    logic w_accept;

    assign w_rd_en       = (r_state == S_RUN);
    assign w_first_tap   = (r_ki == '0) && (r_kj == '0);
    assign w_last_tap    = (r_ki == KI_MAX) && (r_kj == KJ_MAX);
    assign w_filt_wrap   = (r_filt == F_MAX);
    assign w_y_wrap      = (r_out_y == OY_MAX);
    assign w_x_wrap      = (r_out_x == OX_MAX);
    assign w_last_window = w_filt_wrap && w_y_wrap && w_x_wrap;
    assign w_accept      = (r_state == S_WRITE) && res_ready;

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_last_tap) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    r_state <= S_WRITE;
                end
                S_WRITE: begin
                    if (res_ready) begin
                        r_state <= w_last_window ? S_FIN : S_RUN;
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Kernel tap counters (inner loops): j fastest, then i. Both have wrapped
    // back to zero by the time the last tap has been issued.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ki <= '0;
            r_kj <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_ki <= '0;
            r_kj <= '0;
        end else if (w_rd_en) begin
            if (r_kj == KJ_MAX) begin
                r_kj <= '0;
                if (r_ki == KI_MAX) begin
                    r_ki <= '0;
                end else begin
                    r_ki <= r_ki + 1'b1;
                end
            end else begin
                r_kj <= r_kj + 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Window counters (outer loops): filt fastest, then out_y, then out_x.
    // They advance only on an accepted result, so res_* stay stable for the
    // whole of a stall. After the final window all three wrap to zero.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_filt  <= '0;
            r_out_y <= '0;
            r_out_x <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_filt  <= '0;
            r_out_y <= '0;
            r_out_x <= '0;
        end else if (w_accept) begin
            if (w_filt_wrap) begin
                r_filt <= '0;
                if (w_y_wrap) begin
                    r_out_y <= '0;
                    if (w_x_wrap) begin
                        r_out_x <= '0;
                    end else begin
                        r_out_x <= r_out_x + 1'b1;
                    end
                end else begin
                    r_out_y <= r_out_y + 1'b1;
                end
            end else begin
                r_filt <= r_filt + 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // MAC strobes: the read issued in cycle N returns data in cycle N+1
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mac_acc   <= 1'b0;
            r_mac_first <= 1'b0;
            r_mac_last  <= 1'b0;
        end else begin
            r_mac_acc   <= w_rd_en;
            r_mac_first <= w_rd_en && w_first_tap;
            r_mac_last  <= w_rd_en && w_last_tap;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign busy       = (r_state == S_RUN) || (r_state == S_DRAIN) ||
                        (r_state == S_WRITE);
    assign done       = (r_state == S_FIN);

    // Window origin plus kernel offset. The largest value is
    // CONV_X-1 + WEIGHT_X-1 = DATA_X-1, so the sum always fits in AW bits.
    assign data_rd_en = w_rd_en;
    assign data_rd_x  = r_out_x + AW'(r_ki);
    assign data_rd_y  = r_out_y + AW'(r_kj);

    assign wt_rd_en   = w_rd_en;
    assign wt_rd_filt = r_filt;
    assign wt_rd_i    = r_ki;
    assign wt_rd_j    = r_kj;

    assign mac_acc    = r_mac_acc;
    assign mac_first  = r_mac_first;
    assign mac_last   = r_mac_last;

    assign res_valid  = (r_state == S_WRITE);
    assign res_filt   = r_filt;
    assign res_x      = r_out_x;
    assign res_y      = r_out_y;

    assign dbg_state  = r_state;

endmodule

// File: doc/conv_sched.md
Name: conv_sched

Overview:
- Sequencer that time-multiplexes one shared multiply-accumulate unit across all output pixels and filters of the first convolution layer.
- Walks every output position and filter, and issues image-buffer and weight-buffer read addresses for the 5x5 window.
- Drives MAC control strobes aligned to the read data, then hands each finished sum to the result buffer with a valid/ready handshake.
- Sits between the layer-level start/done control and the image buffer, weight buffer, shared MAC and result buffer.

Parameters:
- DATA_X, 28: input image rows.
- DATA_Y, 28: input image columns.
- WEIGHT_X, 5: kernel rows.
- WEIGHT_Y, 5: kernel columns.
- NUM_FILT, 8: number of filters.
- Derived, not overridable: CONV_X = DATA_X-WEIGHT_X+1 (24), CONV_Y = DATA_Y-WEIGHT_Y+1 (24), TAPS = WEIGHT_X*WEIGHT_Y (25). AW = $clog2(DATA_X or DATA_Y, whichever larger) (5), KW = 3, FW = $clog2(NUM_FILT) (3).

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle request to convolve the whole image with all filters.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the final result handshake.
- data_rd_en  out  1  image buffer read strobe.
- data_rd_x  out  AW  image row = out_x + i.
- data_rd_y  out  AW  image column = out_y + j.
- wt_rd_en  out  1  weight buffer read strobe; always equal to data_rd_en.
- wt_rd_filt  out  FW  filter index.
- wt_rd_i  out  KW  kernel row.
- wt_rd_j  out  KW  kernel column.
- mac_acc  out  1  read data valid this cycle; MAC accumulates the product.
- mac_first  out  1  with mac_acc: MAC loads the product instead of adding it.
- mac_last  out  1  with mac_acc: final tap of the window.
- res_valid  out  1  MAC output holds a complete sum.
- res_ready  in  1  result buffer accepts the sum.
- res_filt  out  FW  filter index of the presented result.
- res_x  out  AW  output row of the presented result.
- res_y  out  AW  output column of the presented result.

Behaviour:
- Reset: state IDLE; every output 0, including busy, done, strobes and all indices. Reset mid-operation aborts immediately and the next cycle is IDLE. No partial done is generated.
- Loop order, outer to inner: out_x 0..CONV_X-1, out_y 0..CONV_Y-1, filt 0..NUM_FILT-1, i 0..WEIGHT_X-1, j 0..WEIGHT_Y-1.
- Buffer read latency is exactly 1 cycle. mac_acc, mac_first and mac_last are the read strobe and tap flags delayed by one register stage.
- IDLE:
  - start=1 goes to RUN with all counters at 0; busy=1 the next cycle.
  - start while not IDLE is ignored.
- RUN:
  - Each cycle asserts data_rd_en and wt_rd_en with the current (x+i, y+j, filt, i, j), then advances j, then i.
  - One read is issued per cycle, 25 consecutive cycles per window.
  - After the tap with i=WEIGHT_X-1, j=WEIGHT_Y-1 is issued, go to DRAIN.
- DRAIN:
  - One cycle, no read.
  - The delayed mac_acc+mac_last is asserted this cycle.
  - Go to WRITE.
- WRITE:
  - res_valid=1, with res_filt/res_x/res_y stable and equal to the window just computed.
  - Hold while res_ready=0. No reads and no MAC strobes while stalled.
  - res_valid&res_ready advances the filt/out_y/out_x counters, then returns to RUN.
  - If the accepted window was the last one (x=CONV_X-1, y=CONV_Y-1, f=NUM_FILT-1), go to FIN instead.
- FIN: done=1 for one cycle, busy=0 in the same cycle, then IDLE. start in the FIN cycle is ignored.
- Throughput: 27 cycles per output when res_ready is held high; 4608 outputs; start to done = 124417 cycles.
- mac_first coincides with the first tap (i=0, j=0) of every window. mac_first and mac_last are never asserted together.
- Counters wrap to 0 at their bound; no address ever exceeds DATA_X-1 / DATA_Y-1.

Test Plan:
- rst held 3 cycles, then released with start=0 -> all outputs 0 and state stays IDLE for 10 cycles.
- start pulse, res_ready=1 -> first reads at (0,0,f0,i0,j0) through (4,4,f0,4,4). mac_first in the cycle after the first read; mac_last at cycle 26 after start. res_valid at cycle 27 with res_x=0, res_y=0, res_filt=0. Second window's first read at cycle 28 with filt=1.
- Full run with res_ready=1, reference counter in the bench -> exactly 4608 handshakes in (x,y,f) loop order; done pulse exactly once, at cycle 124417; max data_rd_x=27.
- res_ready low for 10 cycles on the 3rd result -> res_valid and indices held; no data_rd_en/mac_acc during the stall; sequence resumes identically.
- rst asserted during window (5,7,f3) at tap 12 -> next cycle all outputs 0 and IDLE; a new start restarts from (0,0,f0).
- start pulsed again while busy, and in the FIN cycle -> ignored; result count unaffected; one done pulse only.
